cruise_regulator: RTL
=====================

# cruise_regulator

Sequential control stage directly downstream of the cascaded magnitude comparator built from `one_bit_comp` slices. It owns the cruise-control mode FSM and the target-speed register, which feeds the comparator's `b` operand. It consumes the comparator's `gt`/`eq`/`lt` result (current speed vs. target) and, after a stability filter, drives the throttle-up and throttle-down requests.

## Interface
- `W`, 8: speed and target width, unsigned.
- `MIN_SPEED`, 40: lowest engageable and settable target.
- `MAX_SPEED`, 200: highest settable target.
- `STEP`, 5: target increment/decrement per button pulse.
- `HOLD`, 4: consecutive identical comparator samples required before acting (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `on_off` in 1: level; system enable.
- `set` in 1: single-cycle pulse; latch current speed as target.
- `resume` in 1: single-cycle pulse; re-engage with the retained target.
- `brake` in 1: level; brake pedal.
- `inc`, `dec` in 1: single-cycle pulses; adjust the target by `STEP`.
- `speed` in W: current vehicle speed.
- `gt`, `eq`, `lt` in 1: comparator result for speed vs. target.
- `target` out W: target speed, drives comparator `b`.
- `accel`, `decel` out 1: throttle requests, level.
- `active` out 1: high only in CRUISE.
- `state` out 2: current FSM state.

## Operation
- States: OFF=0, STANDBY=1, CRUISE=2, SUSPEND=3.
- **Global rule:** `on_off`=0 in any state forces OFF on the next edge. This has the highest priority after reset.
- **OFF:** `on_off`=1 → STANDBY.
- **STANDBY:** on `set` with `MIN_SPEED`≤`speed`≤`MAX_SPEED`, `target`←`speed` and go to CRUISE. If `speed` is out of range, `set` is ignored.
- **CRUISE:**
  - `brake` → SUSPEND.
  - Otherwise `set` (speed in range) relatches `target`.
  - Otherwise `inc` adds `STEP`, saturating at `MAX_SPEED`; `dec` subtracts `STEP`, saturating at `MIN_SPEED`.
  - `inc` and `dec` together leave `target` unchanged.
- **SUSPEND:**
  - `brake`=1 blocks all transitions.
  - `resume` → CRUISE with `target` unchanged.
  - `set` (speed in range) relatches `target` and goes to CRUISE. `set` wins over `resume`.
- **Priority:** `on_off`=0 > `brake` > `set` > `resume` > `inc`/`dec`.
- **Relation filter:**
  - The sampled relation is LT, EQ or GT.
  - A comparator code that is not one-hot is treated as EQ.
  - A filter count increments, saturating at `HOLD`, when the relation equals the previously sampled relation. Otherwise it loads 1.
  - The count is forced to 0 on any `target` write, and in any state other than CRUISE.
- `accel` = CRUISE & relation LT & count = `HOLD`. `decel` = CRUISE & relation GT & count = `HOLD`. They are never both high.
- `target` is retained across STANDBY and SUSPEND. It clears to 0 only on reset or on entry to OFF.

## Timing
- **Reset values:** `state`=OFF; `target`=0; `accel`=`decel`=`active`=0; filter count 0, relation EQ.
- All inputs are sampled on the rising edge of `clk`. All outputs are registered.
- `target` and `state` update at the edge that samples the command. `active` follows the new state at the same edge.
- After a `target` write, the comparator settles combinationally. The first valid sample of it is taken at the next edge.
- **Latency:** a stable LT first sampled at edge k raises `accel` after edge k+HOLD−1. It falls after the first edge that samples non-LT, exits CRUISE, or writes `target`.
- Brake in CRUISE drops `accel`/`decel` after the same edge that enters SUSPEND.
- **Reset mid-operation:** `rst_n` low clears everything immediately, independent of `clk`. Release is synchronous to the next edge.

## Structure
- Package `cruise_pkg`: state enum and encoding, relation encoding (LT/EQ/GT), default `W`.
- Sub-module `rel_filter`: relation decode, non-one-hot guard, saturating `HOLD` counter with a clear input. It outputs the stable relation and a stable flag.
- The FSM, target register and saturation arithmetic live in `cruise_regulator`. Compute `target`±`STEP` at W+1 bits before clamping, to avoid wrap-around.

## Test plan
- **Engage:** `on_off`=1, `speed`=60, `set` pulse → `state`=CRUISE, `target`=60, `active`=1.
- **Filter latency:** `HOLD`=4, comparator held at lt=1 → `accel` rises after the 4th sampling edge. A one-cycle glitch to eq at sample 3 restarts the count, so `accel` comes after sample 7.
- **Saturation:** `target`=198, `inc` → 200. `inc` again → 200. `target`=42, `dec` → 40. `inc`+`dec` together → unchanged.
- **Suspend/resume:** brake in CRUISE → SUSPEND, `accel`=0. `resume` with `brake`=1 → stays SUSPEND. `brake`=0 then `resume` → CRUISE, `target` unchanged.
- **Priority:** `on_off`=0 with `set`=1 in the same cycle → OFF, `target`=0. `speed`=30, `set` in STANDBY → ignored.
- **Async reset:** assert `rst_n`=0 mid-cycle while `decel`=1 → all outputs 0 immediately, `state`=OFF. The comparator code 3'b110 afterwards behaves as EQ.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared types for the cruise-control stage: FSM state encoding, comparator
// relation encoding and the default speed width.
package cruise_pkg;

    localparam int CRUISE_W = 8;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STANDBY = 2'd1,
        ST_CRUISE  = 2'd2,
        ST_SUSPEND = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REL_LT = 2'd0,
        REL_EQ = 2'd1,
        REL_GT = 2'd2
    } rel_e;

    // Anything other than a clean one-hot code is taken as EQ so a broken
    // comparator can never push the throttle either way.
    function automatic rel_e decode_rel(input logic gt, input logic eq, input logic lt);
        rel_e r;
        case ({gt, eq, lt})
            3'b100:  r = REL_GT;
            3'b001:  r = REL_LT;
            default: r = REL_EQ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rel_filter.sv
// Stability filter on the comparator result: a relation must repeat HOLD
// consecutive samples before it is flagged stable. Outputs are registered.
module rel_filter
    import cruise_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gt_i,
    input  logic eq_i,
    input  logic lt_i,
    input  logic clr_i,
    output rel_e rel_o,
    output logic stable_o
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    rel_e          rel_d, rel_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          stable_d, stable_q;

    always_comb begin
        rel_d = decode_rel(gt_i, eq_i, lt_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (rel_d == rel_q) begin
            if (cnt_q != HOLD_C) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = CW'(1);
        end
        stable_d = (cnt_d == HOLD_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q    <= REL_EQ;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            rel_q    <= rel_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign rel_o    = rel_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/cruise_regulator.sv
// Cruise-control mode FSM and target-speed register; turns the filtered
// speed-vs-target relation into throttle up/down requests.
module cruise_regulator
    import cruise_pkg::*;
#(
    parameter int W         = CRUISE_W,
    parameter int MIN_SPEED = 40,
    parameter int MAX_SPEED = 200,
    parameter int STEP      = 5,
    parameter int HOLD      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         on_off,
    input  logic         set,
    input  logic         resume,
    input  logic         brake,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] speed,
    input  logic         gt,
    input  logic         eq,
    input  logic         lt,
    output logic [W-1:0] target,
    output logic         accel,
    output logic         decel,
    output logic         active,
    output logic [1:0]   state
);

    localparam logic [W:0]   MAX_X  = (W+1)'(MAX_SPEED);
    localparam logic [W:0]   MIN_X  = (W+1)'(MIN_SPEED);
    localparam logic [W:0]   STEP_X = (W+1)'(STEP);
    localparam logic [W-1:0] MAX_T  = W'(MAX_SPEED);
    localparam logic [W-1:0] MIN_T  = W'(MIN_SPEED);

    state_e       state_d, state_q;
    logic [W-1:0] target_d, target_q;
    logic         active_q;
    logic         tgt_wr;
    logic         set_ok;
    logic [W:0]   sum_w, diff_w;
    logic [W-1:0] inc_val, dec_val;
    logic         filt_clr;
    rel_e         filt_rel;
    logic         filt_stable;

    // One spare bit so +STEP near the top and -STEP near zero clamp instead of wrapping.
    always_comb begin
        sum_w   = {1'b0, target_q} + STEP_X;
        diff_w  = {1'b0, target_q} - STEP_X;
        inc_val = (sum_w > MAX_X) ? MAX_T : sum_w[W-1:0];
        dec_val = (diff_w[W] || (diff_w < MIN_X)) ? MIN_T : diff_w[W-1:0];
    end

    assign set_ok = set && (speed >= MIN_T) && (speed <= MAX_T);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tgt_wr   = 1'b0;
        if (!on_off) begin
            state_d  = ST_OFF;
            target_d = '0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_STANDBY;
                ST_STANDBY: begin
                    if (set_ok) begin
                        target_d = speed;
                        tgt_wr   = 1'b1;
                        state_d  = ST_CRUISE;
                    end
                end
                ST_CRUISE: begin
                    if (brake) begin
                        state_d = ST_SUSPEND;
                    end else if (set_ok) begin
                        target_d = speed;
                        tgt_wr   = 1'b1;
                    end else if (inc && !dec) begin
                        target_d = inc_val;
                        tgt_wr   = 1'b1;
                    end else if (dec && !inc) begin
                        target_d = dec_val;
                        tgt_wr   = 1'b1;
                    end
                end
                ST_SUSPEND: begin
                    if (!brake) begin
                        if (set_ok) begin
                            target_d = speed;
                            tgt_wr   = 1'b1;
                            state_d  = ST_CRUISE;
                        end else if (resume) begin
                            state_d = ST_CRUISE;
                        end
                    end
                end
            endcase
        end
    end

    // Count only samples taken while staying in CRUISE against an unchanged target.
    assign filt_clr = tgt_wr || (state_q != ST_CRUISE) || (state_d != ST_CRUISE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            target_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            active_q <= (state_d == ST_CRUISE);
        end
    end

    rel_filter #(
        .HOLD(HOLD)
    ) u_rel_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .gt_i    (gt),
        .eq_i    (eq),
        .lt_i    (lt),
        .clr_i   (filt_clr),
        .rel_o   (filt_rel),
        .stable_o(filt_stable)
    );

    // The filter's stable flag is already cleared outside CRUISE, so these are pure flop decodes.
    assign accel  = filt_stable && (filt_rel == REL_LT);
    assign decel  = filt_stable && (filt_rel == REL_GT);
    assign active = active_q;
    assign target = target_q;
    assign state  = state_q;

endmodule
